// File: rtl/mealy_machine.sv
// Overlapping serial detector for the bit pattern 1-0-1.
// y is a zero-latency Mealy output of the current state and x.
module mealy_machine (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   y_d;

  always_comb begin
    state_d = S0;
    y_d     = 1'b0;
    unique case (state_q)
      S0: state_d = x ? S1 : S0;
      S1: state_d = x ? S1 : S2;
      S2: begin
        state_d = x ? S1 : S0;
        y_d     = x;
      end
      // The unused code 2'b11 recovers to S0 with no detect.
      default: begin
        state_d = S0;
        y_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S0;
    else      state_q <= state_d;
  end

  assign y = y_d & rst;

endmodule

// File: tb/tb_mealy_machine.sv
// Directed-vector bench for the 1-0-1 Mealy detector.
module tb_mealy_machine;

  logic clk;
  logic rst;
  logic x;
  logic y;

  int unsigned n_checks;
  int unsigned n_errors;

  mealy_machine dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one bit mid-cycle, check y before the capturing edge.
  task automatic step(input string tag, input logic xb, input logic ye);
    @(negedge clk);
    x = xb;
    #1;
    check(tag, {1'b0, y}, {1'b0, ye});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    x   = 1'b1;
    #1;
    check({tag, "_y"}, {1'b0, y}, 2'd0);
    check({tag, "_st"}, dut.state_q, 2'd0);
    @(negedge clk);
    x = 1'b0;
    #1;
    check({tag, "_y0"}, {1'b0, y}, 2'd0);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    x   = 1'b0;

    do_reset("rst_a");

    // Alternating stream
    step("alt0", 1'b0, 1'b0);
    step("alt1", 1'b1, 1'b0);
    step("alt2", 1'b0, 1'b0);
    step("alt3", 1'b1, 1'b1);
    step("alt4", 1'b0, 1'b0);
    step("alt5", 1'b1, 1'b1);

    do_reset("rst_b");
    step("nm0", 1'b1, 1'b0);
    step("nm1", 1'b1, 1'b0);
    step("nm2", 1'b0, 1'b0);
    step("nm3", 1'b0, 1'b0);
    step("nm4", 1'b1, 1'b0);

    do_reset("rst_c");
    step("held0", 1'b1, 1'b0);
    step("held1", 1'b0, 1'b0);
    step("held2", 1'b1, 1'b1);
    step("held3", 1'b1, 1'b0);
    step("held4", 1'b0, 1'b0);
    step("held5", 1'b1, 1'b1);

    do_reset("rst_d");
    step("b2b0", 1'b1, 1'b0);
    step("b2b1", 1'b0, 1'b0);
    step("b2b2", 1'b1, 1'b1);
    step("b2b3", 1'b0, 1'b0);
    step("b2b4", 1'b1, 1'b1);

    // Async reset between edges while in S2
    do_reset("rst_e");
    step("ar0", 1'b1, 1'b0);
    step("ar1", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("ar_s2", dut.state_q, 2'd2);
    #1;
    x   = 1'b1;
    rst = 1'b0;
    #1;
    check("ar_st", dut.state_q, 2'd0);
    check("ar_y", {1'b0, y}, 2'd0);
    #1;
    rst = 1'b1;
    step("ar2", 1'b1, 1'b0);
    step("ar3", 1'b1, 1'b0);

    // y follows x combinationally in S2
    do_reset("rst_f");
    step("cb0", 1'b1, 1'b0);
    step("cb1", 1'b0, 1'b0);
    step("cb_x1", 1'b1, 1'b1);
    x = 1'b0;
    #1;
    check("cb_x0", {1'b0, y}, 2'd0);
    x = 1'b1;
    #1;
    check("cb_x1b", {1'b0, y}, 2'd1);
    @(posedge clk);
    #1;
    check("cb_st", dut.state_q, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
